// File: rtl/buffered_blocking_channel_pkg.sv
// rtl/buffered_blocking_channel_pkg.sv - shared direct-message layout and channel sizing helpers
package buffered_blocking_channel_pkg;

    localparam int CODE_DISTANCE    = 5;
    // Each address coordinate must encode 0..CODE_DISTANCE; the receiver address has three coordinates.
    localparam int COORD_WIDTH      = $clog2(CODE_DISTANCE + 1);
    localparam int ADDRESS_WIDTH    = 3 * COORD_WIDTH;
    localparam int DIRECT_MSG_WIDTH = ADDRESS_WIDTH + 2;

    localparam int MSG_BOUNDARY_BIT = 0;
    localparam int MSG_ODD_ROOT_BIT = 1;
    localparam int MSG_ADDR_LSB     = 2;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] receiver;
        logic                     is_odd_cardinality_root;
        logic                     is_touching_boundary;
    } direct_msg_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/buffered_blocking_channel.sv
// rtl/buffered_blocking_channel.sv - blocking FIFO channel between two processing units
module buffered_blocking_channel
    import buffered_blocking_channel_pkg::*;
#(
    parameter int DATA_WIDTH = DIRECT_MSG_WIDTH,
    parameter int DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       in_valid,
    output logic                       in_is_full,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_is_taken,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;

    logic w_full;
    logic w_valid;
    logic w_push;
    logic w_pop;

    // Wrap by compare so non-power-of-two depths never index past the array.
    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_valid = (r_count != '0);
    assign w_push  = in_valid & ~w_full & ~flush;
    assign w_pop   = w_valid & out_is_taken & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= f_next(r_tail);
            if (w_pop)  r_head <= f_next(r_head);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately left unreset; out_data is only meaningful while out_valid=1.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= in_data;
    end

    assign in_is_full = w_full;
    assign out_valid  = w_valid;
    assign out_data   = r_mem[r_head];
    assign count      = r_count;

endmodule
